mem_access_unit: RTL and testbench

Load/store sequencer between the MIPS datapath and the word-organised data RAM. Accepts one byte, halfword or word request from the core, drives the RAM's address/write_data/MemWrite/MemRead, and returns aligned, sign- or zero-extended load data. Sub-word stores use read-modify-write, so the RAM stays word-only. Misaligned requests are flagged and never reach memory.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_lane_align.sv | 46 ++++
 rtl/mem_access_unit.sv | 130 +++++++++++++
 tb/tb_mem_access_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the load/store sequencer
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00ff;
    localparam logic [31:0] HALF_MASK = 32'h0000_ffff;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian lane extract/extend and sub-word store merge
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    input  logic [31:0] rd_word,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [4:0]  shift;
    logic [31:0] lane_mask;

    always_comb begin
        case (offset)
            2'd0:    byte_lane = rd_word[7:0];
            2'd1:    byte_lane = rd_word[15:8];
            2'd2:    byte_lane = rd_word[23:16];
            default: byte_lane = rd_word[31:24];
        endcase
        half_lane = offset[1] ? rd_word[31:16] : rd_word[15:0];

        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            SZ_HALF: load_data = {{16{sign_ext & half_lane[15]}}, half_lane};
            default: load_data = rd_word;
        endcase
    end

    // Halfword offsets are always even here, so the same shift covers both sizes.
    always_comb begin
        shift     = {offset, 3'b000};
        lane_mask = (size == SZ_BYTE) ? BYTE_MASK : HALF_MASK;
        if (size == SZ_BYTE || size == SZ_HALF)
            merged = (rd_word & ~(lane_mask << shift))
                   | (({16'h0000, wdata} & lane_mask) << shift);
        else
            merged = rd_word;
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer between core and word-only data RAM
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  misaligned,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  MemWrite,
    output logic                  MemRead,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    state_t      state;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_sign;
    logic [1:0]  lat_off;
    logic [15:0] lat_wdata;

    logic        bad_req;
    logic [31:0] load_data;
    logic [31:0] merged;

    always_comb begin
        bad_req = 1'b0;
        case (size)
            SZ_BYTE: bad_req = 1'b0;
            SZ_HALF: bad_req = addr[0];
            SZ_WORD: bad_req = (addr[1:0] != 2'b00);
            default: bad_req = 1'b1;
        endcase
    end

    mem_lane_align u_align (
        .size      (lat_size),
        .offset    (lat_off),
        .sign_ext  (lat_sign),
        .rd_word   (mem_read_data),
        .wdata     (lat_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    // All RAM-facing outputs are registered so they only move on rising edges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            lat_we         <= 1'b0;
            lat_size       <= SZ_BYTE;
            lat_sign       <= 1'b0;
            lat_off        <= 2'b00;
            lat_wdata      <= 16'h0000;
            busy           <= 1'b0;
            done           <= 1'b0;
            misaligned     <= 1'b0;
            rdata          <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            MemWrite       <= 1'b0;
            MemRead        <= 1'b0;
        end else begin
            busy       <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            MemWrite   <= 1'b0;
            MemRead    <= 1'b0;
            case (state)
                ST_IDLE, ST_RESP: begin
                    state <= ST_IDLE;
                    if (req) begin
                        lat_we    <= we;
                        lat_size  <= size;
                        lat_sign  <= sign_ext;
                        lat_off   <= addr[1:0];
                        lat_wdata <= wdata[15:0];
                        if (bad_req) begin
                            state      <= ST_RESP;
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                        end else begin
                            busy        <= 1'b1;
                            mem_address <= {2'b00, addr[ADDR_WIDTH-1:2]};
                            if (we && size == SZ_WORD) begin
                                state          <= ST_WR;
                                MemWrite       <= 1'b1;
                                mem_write_data <= wdata;
                            end else begin
                                state   <= ST_RD;
                                MemRead <= 1'b1;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (lat_we) begin
                        // Sub-word store: old word is on mem_read_data now, merge on the fly.
                        state          <= ST_WR;
                        busy           <= 1'b1;
                        MemWrite       <= 1'b1;
                        mem_write_data <= merged;
                    end else begin
                        state <= ST_RESP;
                        done  <= 1'b1;
                        rdata <= load_data;
                    end
                end
                ST_WR: begin
                    state <= ST_RESP;
                    done  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, misaligned, MemWrite, MemRead;
    logic [31:0] rdata, mem_address, mem_write_data, mem_read_data;

    logic [31:0] ram [64];
    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req            (req),
        .we             (we),
        .size           (size),
        .sign_ext       (sign_ext),
        .addr           (addr),
        .wdata          (wdata),
        .busy           (busy),
        .done           (done),
        .misaligned     (misaligned),
        .rdata          (rdata),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .MemWrite       (MemWrite),
        .MemRead        (MemRead),
        .mem_read_data  (mem_read_data)
    );

    assign mem_read_data = (mem_address[31:6] == 26'd0) ? ram[mem_address[5:0]] : 32'h0;

    always @(negedge clock)
        if (MemWrite && mem_address[31:6] == 26'd0)
            ram[mem_address[5:0]] <= mem_write_data;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic do_op(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output int nrd, output int nwr, output int ovl,
                         output logic mis, output logic [31:0] rd, output logic [31:0] wdat);
        @(negedge clock);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(posedge clock);
        lat = 99; nrd = 0; nwr = 0; ovl = 0; mis = 1'b0; rd = 32'h0; wdat = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            req = 1'b0;
            if (MemRead) nrd++;
            if (MemWrite) begin nwr++; wdat = mem_write_data; end
            if (MemRead && MemWrite) ovl++;
            if (done) begin
                lat = c; mis = misaligned; rd = rdata;
                break;
            end
        end
    endtask

    typedef struct {
        logic [31:0] init;
        logic        w;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rdata;
        logic [31:0] exp_ram;
        int          exp_lat;
        logic        exp_mis;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    vec_t vt [13];

    initial begin
        int lat, nrd, nwr, ovl, dcount;
        logic mis;
        logic [31:0] rd, wdat, model_rdata, v;
        logic [7:0] mb [256];

        for (int i = 0; i < 64; i++) ram[i] = 32'h0;

        //           init          w     sz     sx    addr    wdata         rdata         ram           lat mis  rd wr
        vt[0]  = '{32'h0000_0000, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0000_0000, 32'hDEADBEEF, 2, 1'b0, 0, 1};
        vt[1]  = '{32'hDEADBEEF, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 2, 1'b0, 1, 0};
        vt[2]  = '{32'h11223344, 1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA, 32'hDEADBEEF, 32'h11AA3344, 3, 1'b0, 1, 1};
        vt[3]  = '{32'h8000_00F0, 1'b0, 2'b00, 1'b1, 32'h10, 32'h0,        32'hFFFF_FFF0, 32'h8000_00F0, 2, 1'b0, 1, 0};
        vt[4]  = '{32'h8000_00F0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        32'h0000_00F0, 32'h8000_00F0, 2, 1'b0, 1, 0};
        vt[5]  = '{32'h8000_00F0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'hFFFF_8000, 32'h8000_00F0, 2, 1'b0, 1, 0};
        vt[6]  = '{32'h8000_00F0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'h0000_8000, 32'h8000_00F0, 2, 1'b0, 1, 0};
        vt[7]  = '{32'h8000_00F0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'hFFFF_FF80, 32'h8000_00F0, 2, 1'b0, 1, 0};
        vt[8]  = '{32'h8000_00F0, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0,        32'hFFFF_FF80, 32'h8000_00F0, 1, 1'b1, 0, 0};
        vt[9]  = '{32'h8000_00F0, 1'b1, 2'b01, 1'b0, 32'h13, 32'h1234,     32'hFFFF_FF80, 32'h8000_00F0, 1, 1'b1, 0, 0};
        vt[10] = '{32'h8000_00F0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        32'hFFFF_FF80, 32'h8000_00F0, 1, 1'b1, 0, 0};
        vt[11] = '{32'hAABBCCDD, 1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF, 32'hFFFF_FF80, 32'hBEEFCCDD, 3, 1'b0, 1, 1};
        vt[12] = '{32'h0000_A500, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0,        32'h0000_00A5, 32'h0000_A500, 2, 1'b0, 1, 0};

        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_mis", {31'h0, misaligned}, 32'h0);
        chk("rst_memrw", {30'h0, MemRead, MemWrite}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_maddr", mem_address, 32'h0);
        chk("rst_mwdata", mem_write_data, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            ram[vt[i].a[7:2]] = vt[i].init;
            do_op(vt[i].w, vt[i].sz, vt[i].sx, vt[i].a, vt[i].wd, lat, nrd, nwr, ovl, mis, rd, wdat);
            chk($sformatf("v%0d_lat", i), lat, vt[i].exp_lat);
            chk($sformatf("v%0d_mis", i), {31'h0, mis}, {31'h0, vt[i].exp_mis});
            chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rdata);
            chk($sformatf("v%0d_nrd", i), nrd, vt[i].exp_rd);
            chk($sformatf("v%0d_nwr", i), nwr, vt[i].exp_wr);
            chk($sformatf("v%0d_ovl", i), ovl, 0);
            if (vt[i].exp_wr != 0) chk($sformatf("v%0d_wdata", i), wdat, vt[i].exp_ram);
            @(negedge clock);
            chk($sformatf("v%0d_ram", i), ram[vt[i].a[7:2]], vt[i].exp_ram);
        end

        // Back-to-back: second request accepted in RESP with no idle cycle.
        ram[8] = 32'h55667788;
        ram[9] = 32'h99AABBCC;
        @(negedge clock);
        req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h20;
        @(posedge clock);
        @(negedge clock);
        chk("b2b_c1_rd", {30'h0, busy, MemRead}, 32'h3);
        @(negedge clock);
        chk("b2b_c2_done", {31'h0, done}, 32'h1);
        chk("b2b_c2_rdata", rdata, 32'h55667788);
        addr = 32'h24;
        @(negedge clock);
        req = 1'b0;
        chk("b2b_c3_rd", {30'h0, done, MemRead}, 32'h1);
        @(negedge clock);
        chk("b2b_c4_done", {31'h0, done}, 32'h1);
        chk("b2b_c4_rdata", rdata, 32'h99AABBCC);

        // A req held during RD must not produce a second operation.
        @(negedge clock);
        @(negedge clock);
        req = 1'b1; addr = 32'h20;
        @(posedge clock);
        @(negedge clock);
        chk("rdreq_c1_busy", {31'h0, busy}, 32'h1);
        @(negedge clock);
        req = 1'b0;
        chk("rdreq_c2_done", {31'h0, done}, 32'h1);
        dcount = 0;
        repeat (4) begin
            @(negedge clock);
            if (done || busy) dcount++;
        end
        chk("rdreq_no_second", dcount, 0);

        // Reset asserted inside the WR cycle before the falling edge.
        ram[5] = 32'h01020304;
        @(negedge clock);
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h14; wdata = 32'hCAFEF00D;
        @(posedge clock);
        #2;
        chk("rstmid_wr_on", {31'h0, MemWrite}, 32'h1);
        reset_n = 1'b0;
        req = 1'b0;
        #1;
        chk("rstmid_memwrite", {31'h0, MemWrite}, 32'h0);
        chk("rstmid_flags", {29'h0, busy, done, misaligned}, 32'h0);
        chk("rstmid_rdata", rdata, 32'h0);
        chk("rstmid_maddr", mem_address, 32'h0);
        chk("rstmid_mwdata", mem_write_data, 32'h0);
        @(negedge clock);
        #1;
        chk("rstmid_ram", ram[5], 32'h01020304);
        reset_n = 1'b1;
        do_op(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, lat, nrd, nwr, ovl, mis, rd, wdat);
        chk("postrst_lat", lat, 2);
        chk("postrst_rdata", rd, 32'h01020304);
        model_rdata = 32'h01020304;

        // Randomised ops against a byte-addressed memory model.
        for (int i = 0; i < 64; i++)
            for (int k = 0; k < 4; k++) mb[4*i+k] = ram[i][8*k +: 8];
        for (int n = 0; n < 300; n++) begin
            logic w, sx, bad_a;
            logic [1:0] sz;
            logic [31:0] a, wd;
            int nb, elat;
            w = 1'($urandom_range(0, 1));
            sx = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a = 32'($urandom_range(0, 255));
            wd = $urandom;
            nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            bad_a = (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0);
            if (bad_a) begin
                elat = 1;
            end else if (!w) begin
                elat = 2;
                v = 32'h0;
                for (int b = 0; b < nb; b++) v = v | (32'(mb[a+b]) << (8*b));
                if (sx && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
                model_rdata = v;
            end else begin
                elat = (nb == 4) ? 2 : 3;
                for (int b = 0; b < nb; b++) mb[a+b] = wd[8*b +: 8];
            end
            do_op(w, sz, sx, a, wd, lat, nrd, nwr, ovl, mis, rd, wdat);
            chk($sformatf("rnd%0d_lat", n), lat, elat);
            chk($sformatf("rnd%0d_mis", n), {31'h0, mis}, {31'h0, bad_a});
            chk($sformatf("rnd%0d_rdata", n), rd, model_rdata);
            chk($sformatf("rnd%0d_ovl", n), ovl, 0);
        end
        @(negedge clock);
        for (int i = 0; i < 64; i++)
            chk($sformatf("final_ram%0d", i), ram[i], {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
